// File: rtl/uart_report_pkg.sv
// ============================================================================
// Module   : uart_report_pkg
// Brief    : Shared constants, frame length and FSM state type for the
//            UART time reporter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_report_pkg;

   localparam logic [7:0] ZERO  = 8'h30;
   localparam logic [7:0] COLON = 8'h3A;
   localparam logic [7:0] DOT   = 8'h2E;
   localparam logic [7:0] CR    = 8'h0D;
   localparam logic [7:0] LF    = 8'h0A;

`ifdef REPORT_MSEC_EN
   localparam int unsigned FRAME_LEN = 13;
`else
   localparam int unsigned FRAME_LEN = 10;
`endif

   localparam int unsigned IDX_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

`default_nettype wire

// File: rtl/uart_time_reporter_if.sv
// ============================================================================
// Module   : uart_time_reporter_if
// Brief    : TX FIFO write port (data, strobe, full backpressure).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_time_reporter_if;

   logic [7:0] w_wdata;
   logic       w_wr;
   logic       w_full;

   modport master (output w_wdata, output w_wr, input  w_full);
   modport slave  (input  w_wdata, input  w_wr, output w_full);

endinterface

`default_nettype wire

// File: rtl/bin2ascii_2d.sv
// ============================================================================
// Module   : bin2ascii_2d
// Brief    : Combinational 0-99 binary to two ASCII decimal digits.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bin2ascii_2d
   import uart_report_pkg::*;
(
   input  wire logic [6:0] i_val,
   output logic      [7:0] o_tens,
   output logic      [7:0] o_ones
);

   logic [6:0] w_tens;
   logic [6:0] w_ones;

   assign w_tens = i_val / 7'd10;
   assign w_ones = i_val % 7'd10;

   assign o_tens = ZERO + {1'b0, w_tens};
   assign o_ones = ZERO + {1'b0, w_ones};

endmodule

`default_nettype wire

// File: rtl/uart_time_reporter.sv
// ============================================================================
// Module   : uart_time_reporter
// Brief    : Snapshots h/m/s(/cs) on request and writes "HH:MM:SS[.CC]\r\n"
//            byte by byte into the TX FIFO. Macro REPORT_MSEC_EN adds ".CC".
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_time_reporter
   import uart_report_pkg::*;
#(
   parameter int unsigned HOUR_MAX = 23
)(
   input  wire logic       clk,
   input  wire logic       rst,
   input  wire logic       i_report,
   input  wire logic [4:0] i_hour,
   input  wire logic [5:0] i_min,
   input  wire logic [5:0] i_sec,
   input  wire logic [6:0] i_msec,
   uart_time_reporter_if.master if_fifo,
   output logic            o_busy,
   output logic            o_done
);

   localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(FRAME_LEN - 1);

   state_t           r_state, w_state_nx;
   logic [IDX_W-1:0] r_idx, w_idx_nx;
   logic             w_load;
   logic             w_wr;
   logic [7:0]       w_wdata;
   logic             w_busy;
   logic             w_done;
   logic [7:0]       w_frame_byte;

   logic [4:0]       r_hour;
   logic [5:0]       r_min;
   logic [5:0]       r_sec;
   logic [7:0]       w_hour_t, w_hour_o, w_min_t, w_min_o, w_sec_t, w_sec_o;

`ifdef REPORT_MSEC_EN
   logic [6:0]       r_msec;
   logic [7:0]       w_msec_t, w_msec_o;
`else
   logic             w_unused_msec;
   assign w_unused_msec = ^i_msec;
`endif

   // Hour is compared at 6 bits so a HOUR_MAX above 31 never truncates.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hour <= '0;
         r_min  <= '0;
         r_sec  <= '0;
`ifdef REPORT_MSEC_EN
         r_msec <= '0;
`endif
      end else if (w_load) begin
         r_hour <= ({1'b0, i_hour} > 6'(HOUR_MAX)) ? 5'(HOUR_MAX) : i_hour;
         r_min  <= (i_min > 6'd59) ? 6'd59 : i_min;
         r_sec  <= (i_sec > 6'd59) ? 6'd59 : i_sec;
`ifdef REPORT_MSEC_EN
         r_msec <= (i_msec > 7'd99) ? 7'd99 : i_msec;
`endif
      end
   end

   bin2ascii_2d u_hour (.i_val({2'b00, r_hour}), .o_tens(w_hour_t), .o_ones(w_hour_o));
   bin2ascii_2d u_min  (.i_val({1'b0, r_min}),   .o_tens(w_min_t),  .o_ones(w_min_o));
   bin2ascii_2d u_sec  (.i_val({1'b0, r_sec}),   .o_tens(w_sec_t),  .o_ones(w_sec_o));
`ifdef REPORT_MSEC_EN
   bin2ascii_2d u_msec (.i_val(r_msec),          .o_tens(w_msec_t), .o_ones(w_msec_o));
`endif

   always_comb begin
      w_frame_byte = 8'h00;
      case (r_idx)
         4'd0:    w_frame_byte = w_hour_t;
         4'd1:    w_frame_byte = w_hour_o;
         4'd2:    w_frame_byte = COLON;
         4'd3:    w_frame_byte = w_min_t;
         4'd4:    w_frame_byte = w_min_o;
         4'd5:    w_frame_byte = COLON;
         4'd6:    w_frame_byte = w_sec_t;
         4'd7:    w_frame_byte = w_sec_o;
`ifdef REPORT_MSEC_EN
         4'd8:    w_frame_byte = DOT;
         4'd9:    w_frame_byte = w_msec_t;
         4'd10:   w_frame_byte = w_msec_o;
         4'd11:   w_frame_byte = CR;
         4'd12:   w_frame_byte = LF;
`else
         4'd8:    w_frame_byte = CR;
         4'd9:    w_frame_byte = LF;
`endif
         default: w_frame_byte = 8'h00;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_idx   <= '0;
      end else begin
         r_state <= w_state_nx;
         r_idx   <= w_idx_nx;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      w_idx_nx   = r_idx;
      w_load     = 1'b0;
      w_wr       = 1'b0;
      w_wdata    = 8'h00;
      w_busy     = 1'b0;
      w_done     = 1'b0;
      case (r_state)
         IDLE: begin
            if (i_report) begin
               w_load     = 1'b1;
               w_idx_nx   = '0;
               w_state_nx = SEND;
            end
         end
         SEND: begin
            w_busy  = 1'b1;
            w_wdata = w_frame_byte;
            w_wr    = !if_fifo.w_full;
            // The index only moves on an accepted write, so a stall repeats the pending byte.
            if (w_wr) begin
               if (r_idx == c_LAST_IDX) begin
                  w_idx_nx   = '0;
                  w_state_nx = DONE;
               end else begin
                  w_idx_nx = r_idx + 1'b1;
               end
            end
         end
         DONE: begin
            w_busy     = 1'b1;
            w_done     = 1'b1;
            w_state_nx = IDLE;
         end
         default: begin
            w_state_nx = IDLE;
            w_idx_nx   = '0;
         end
      endcase
   end

   assign if_fifo.w_wdata = w_wdata;
   assign if_fifo.w_wr    = w_wr;
   assign o_busy          = w_busy;
   assign o_done          = w_done;

endmodule

`default_nettype wire

// File: tb/tb_uart_time_reporter.sv
// ============================================================================
// Module   : tb_uart_time_reporter
// Brief    : Directed self-checking bench for uart_time_reporter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_time_reporter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       i_report = 1'b0;
   logic [4:0] i_hour = '0;
   logic [5:0] i_min = '0;
   logic [5:0] i_sec = '0;
   logic [6:0] i_msec = '0;
   logic       o_busy;
   logic       o_done;

   int vectors = 0;
   int miscompares = 0;

   logic [7:0] exp_bytes [13];
   int         exp_len = 0;

   logic [7:0] f_1234 [13] = '{8'h31, 8'h32, 8'h3A, 8'h33, 8'h34, 8'h3A, 8'h35, 8'h36,
                               8'h2E, 8'h37, 8'h38, 8'h0D, 8'h0A};
   logic [7:0] f_clmp [13] = '{8'h32, 8'h33, 8'h3A, 8'h35, 8'h39, 8'h3A, 8'h35, 8'h39,
                               8'h2E, 8'h39, 8'h39, 8'h0D, 8'h0A};
   logic [7:0] f_zero [13] = '{8'h30, 8'h30, 8'h3A, 8'h30, 8'h30, 8'h3A, 8'h30, 8'h30,
                               8'h2E, 8'h30, 8'h30, 8'h0D, 8'h0A};

   uart_time_reporter_if u_if ();

   uart_time_reporter #(.HOUR_MAX(23)) dut (
      .clk      (clk),
      .rst      (rst),
      .i_report (i_report),
      .i_hour   (i_hour),
      .i_min    (i_min),
      .i_sec    (i_sec),
      .i_msec   (i_msec),
      .if_fifo  (u_if),
      .o_busy   (o_busy),
      .o_done   (o_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Without the centisecond field the frame is the first 8 bytes then CR LF.
   task automatic set_exp(input logic [7:0] b [13]);
`ifdef REPORT_MSEC_EN
      for (int i = 0; i < 13; i++) exp_bytes[i] = b[i];
      exp_len = 13;
`else
      for (int i = 0; i < 8; i++) exp_bytes[i] = b[i];
      exp_bytes[8] = 8'h0D;
      exp_bytes[9] = 8'h0A;
      exp_len = 10;
`endif
   endtask

   task automatic set_time(input int h, input int m, input int s, input int c);
      i_hour = 5'(h);
      i_min  = 6'(m);
      i_sec  = 6'(s);
      i_msec = 7'(c);
   endtask

   // Entered just after a falling edge; the request is sampled at the next rising edge (N).
   task automatic run_frame(input int stall_from, input int stall_n, input bit disturb);
      int  got;
      bit  done_seen;
      int  exp_done;
      got       = 0;
      done_seen = 1'b0;
      exp_done  = exp_len + stall_n + 1;
      chk("pre_busy", {31'd0, o_busy}, 32'd0);
      i_report = 1'b1;
      @(negedge clk);
      i_report = 1'b0;
      for (int cyc = 1; cyc <= 60 && !done_seen; cyc++) begin
         u_if.w_full = (cyc >= stall_from) && (cyc < stall_from + stall_n);
         if (disturb) begin
            if (cyc == 5) set_time(1, 2, 3, 4);
            if (cyc == 6) i_report = 1'b1;
            if (cyc == 7) i_report = 1'b0;
         end
         #1;
         if (cyc <= exp_len + stall_n) chk($sformatf("busy_c%0d", cyc), {31'd0, o_busy}, 32'd1);
         if (u_if.w_full) chk($sformatf("wr_stall_c%0d", cyc), {31'd0, u_if.w_wr}, 32'd0);
         if (u_if.w_wr) begin
            if (got < exp_len)
               chk($sformatf("byte%0d", got), {24'd0, u_if.w_wdata}, {24'd0, exp_bytes[got]});
            else
               chk("extra_byte", 32'd1, 32'd0);
            got++;
         end
         if (o_done) begin
            chk("done_cycle", cyc, exp_done);
            chk("byte_count", got, exp_len);
            done_seen = 1'b1;
         end
         @(negedge clk);
      end
      u_if.w_full = 1'b0;
      i_report    = 1'b0;
      if (!done_seen) chk("done_timeout", 32'd0, 32'd1);
      #1;
      chk("idle_busy", {31'd0, o_busy}, 32'd0);
      chk("idle_done", {31'd0, o_done}, 32'd0);
      for (int k = 0; k < 3; k++) begin
         chk("idle_wr", {31'd0, u_if.w_wr}, 32'd0);
         @(negedge clk);
         #1;
      end
   endtask

   initial begin
      u_if.w_full = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("rst_wr",    {31'd0, u_if.w_wr},    32'd0);
      chk("rst_busy",  {31'd0, o_busy},       32'd0);
      chk("rst_done",  {31'd0, o_done},       32'd0);
      chk("rst_wdata", {24'd0, u_if.w_wdata}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      #1;

      set_time(12, 34, 56, 78);
      set_exp(f_1234);
      run_frame(0, 0, 1'b0);

      set_time(12, 34, 56, 78);
      run_frame(4, 4, 1'b0);

      set_time(12, 34, 56, 78);
      run_frame(0, 0, 1'b1);

      set_time(31, 63, 60, 120);
      set_exp(f_clmp);
      run_frame(0, 0, 1'b0);

      set_time(0, 0, 0, 0);
      set_exp(f_zero);
      run_frame(0, 0, 1'b0);

      // Abandon a frame after six bytes with an asynchronous reset.
      set_time(12, 34, 56, 78);
      set_exp(f_1234);
      i_report = 1'b1;
      @(negedge clk);
      i_report = 1'b0;
      for (int cyc = 1; cyc <= 6; cyc++) begin
         #1;
         chk($sformatf("part_wr%0d", cyc), {31'd0, u_if.w_wr}, 32'd1);
         chk($sformatf("part_byte%0d", cyc - 1), {24'd0, u_if.w_wdata}, {24'd0, exp_bytes[cyc - 1]});
         @(negedge clk);
      end
      rst = 1'b1;
      #1;
      chk("mid_rst_wr",    {31'd0, u_if.w_wr},    32'd0);
      chk("mid_rst_busy",  {31'd0, o_busy},       32'd0);
      chk("mid_rst_wdata", {24'd0, u_if.w_wdata}, 32'd0);
      @(negedge clk);
      #1;
      chk("post_rst_wr",   {31'd0, u_if.w_wr}, 32'd0);
      chk("post_rst_busy", {31'd0, o_busy},    32'd0);
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         #1;
         chk("no_append_wr", {31'd0, u_if.w_wr}, 32'd0);
      end
      run_frame(0, 0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
